// File: rtl/cache_miss_controller.sv
// cache_miss_controller
// Services a miss from the 4-line fully-associative cache against the shared
// 32x8 backing RAM. It writes back a valid, dirty victim first, then reads the
// requested word and presents it for one cycle with a fill strobe. It also keeps
// saturating counts of accepted misses and of writebacks.
//
// Ports
//   clock, reset        : system clock and asynchronous active-high reset
//   miss_req, miss_addr : single-cycle miss strobe and the word address that missed
//   victim_*            : state of the LRU victim line, sampled when a miss is accepted
//   mem_address/data/wren, mem_q : RAM port; mem_q is valid RAM_LATENCY cycles
//                                  after the address is sampled
//   busy                : a miss is in flight
//   fill_valid/addr/data: one-cycle fill strobe; addr and data hold until the next fill
//   overrun             : sticky; set when miss_req arrives while busy
//   miss_count, wb_count: saturating statistics
//
// state  | meaning
// IDLE   | waiting for miss_req, RAM port parked at zero
// WB     | one-cycle write of the victim line back to RAM
// RD     | one-cycle read address issue for the missed word
// WAIT   | RAM_LATENCY cycles for mem_q; the last one captures the data
// FILL   | one-cycle fill strobe to the cache
module cache_miss_controller #(
   parameter int RAM_LATENCY = 1,
   parameter int CNT_W       = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             miss_req,
   input  logic [4:0]       miss_addr,
   input  logic             victim_valid,
   input  logic             victim_dirty,
   input  logic [4:0]       victim_tag,
   input  logic [7:0]       victim_data,
   output logic [4:0]       mem_address,
   output logic [7:0]       mem_data,
   output logic             mem_wren,
   input  logic [7:0]       mem_q,
   output logic             busy,
   output logic             fill_valid,
   output logic [4:0]       fill_addr,
   output logic [7:0]       fill_data,
   output logic             overrun,
   output logic [CNT_W-1:0] miss_count,
   output logic [CNT_W-1:0] wb_count
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_WB   = 3'd1,
      S_RD   = 3'd2,
      S_WAIT = 3'd3,
      S_FILL = 3'd4
   } state_t;

   localparam logic [1:0]       WAIT_LOAD = 2'(RAM_LATENCY - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

   state_t           r_state;
   state_t           w_next;
   logic [4:0]       r_addr;
   logic [4:0]       r_tag;
   logic [7:0]       r_vdata;
   logic [1:0]       r_wait_cnt;
   logic [4:0]       r_fill_addr;
   logic [7:0]       r_fill_data;
   logic             r_overrun;
   logic [CNT_W-1:0] r_miss_cnt;
   logic [CNT_W-1:0] r_wb_cnt;
   logic             w_accept;
   logic             w_wait_done;

   assign w_accept    = (r_state == S_IDLE) && miss_req;
   assign w_wait_done = (r_state == S_WAIT) && (r_wait_cnt == 2'd0);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Outputs decode from registered state only, so nothing on the input side
   // can reach an output without passing through a flop.
   always_comb begin
      w_next      = r_state;
      busy        = 1'b1;
      mem_wren    = 1'b0;
      mem_address = 5'd0;
      mem_data    = 8'd0;
      fill_valid  = 1'b0;
      case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            if (miss_req) begin
               w_next = (victim_valid && victim_dirty) ? S_WB : S_RD;
            end
         end
         S_WB: begin
            mem_address = r_tag;
            mem_data    = r_vdata;
            mem_wren    = 1'b1;
            w_next      = S_RD;
         end
         S_RD: begin
            mem_address = r_addr;
            w_next      = S_WAIT;
         end
         S_WAIT: begin
            // Address held so a pipelined RAM keeps returning the same word.
            mem_address = r_addr;
            if (r_wait_cnt == 2'd0) begin
               w_next = S_FILL;
            end
         end
         S_FILL: begin
            fill_valid = 1'b1;
            w_next     = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_addr      <= 5'd0;
         r_tag       <= 5'd0;
         r_vdata     <= 8'd0;
         r_wait_cnt  <= 2'd0;
         r_fill_addr <= 5'd0;
         r_fill_data <= 8'd0;
         r_overrun   <= 1'b0;
         r_miss_cnt  <= '0;
         r_wb_cnt    <= '0;
      end else begin
         if (w_accept) begin
            r_addr  <= miss_addr;
            r_tag   <= victim_tag;
            r_vdata <= victim_data;
            if (r_miss_cnt != CNT_MAX) begin
               r_miss_cnt <= r_miss_cnt + 1'b1;
            end
         end
         if (miss_req && (r_state != S_IDLE)) begin
            r_overrun <= 1'b1;
         end
         if ((r_state == S_WB) && (r_wb_cnt != CNT_MAX)) begin
            r_wb_cnt <= r_wb_cnt + 1'b1;
         end
         if (r_state == S_RD) begin
            r_wait_cnt <= WAIT_LOAD;
         end else if ((r_state == S_WAIT) && (r_wait_cnt != 2'd0)) begin
            r_wait_cnt <= r_wait_cnt - 1'b1;
         end
         if (w_wait_done) begin
            r_fill_data <= mem_q;
            r_fill_addr <= r_addr;
         end
      end
   end

   assign fill_addr  = r_fill_addr;
   assign fill_data  = r_fill_data;
   assign overrun    = r_overrun;
   assign miss_count = r_miss_cnt;
   assign wb_count   = r_wb_cnt;

endmodule

// File: tb/tb_cache_miss_controller.sv
module tb_cache_miss_controller;

   logic       clock = 1'b0;
   logic       reset;
   logic       miss_req_a, miss_req_b;
   logic [4:0] miss_addr, victim_tag;
   logic       victim_valid, victim_dirty;
   logic [7:0] victim_data;

   logic [4:0] mem_address_a, mem_address_b, fill_addr_a, fill_addr_b;
   logic [7:0] mem_data_a, mem_data_b, mem_q_a, mem_q_b, fill_data_a, fill_data_b;
   logic       mem_wren_a, mem_wren_b, busy_a, busy_b, fill_valid_a, fill_valid_b;
   logic       overrun_a, overrun_b;
   logic [7:0] miss_count_a, miss_count_b, wb_count_a, wb_count_b;

   logic       ld_en;
   logic [4:0] ld_addr;
   logic [7:0] ld_data;
   logic [7:0] ram_a [32];
   logic [7:0] ram_b [32];
   logic [7:0] pipe_a [3];
   logic [7:0] pipe_b [3];

   int checks = 0;
   int errors = 0;
   int lat;
   int fills;

   always #5 clock = ~clock;

   cache_miss_controller #(.RAM_LATENCY(1), .CNT_W(8)) dut_a (
      .clock(clock), .reset(reset), .miss_req(miss_req_a), .miss_addr(miss_addr),
      .victim_valid(victim_valid), .victim_dirty(victim_dirty),
      .victim_tag(victim_tag), .victim_data(victim_data),
      .mem_address(mem_address_a), .mem_data(mem_data_a), .mem_wren(mem_wren_a),
      .mem_q(mem_q_a), .busy(busy_a), .fill_valid(fill_valid_a),
      .fill_addr(fill_addr_a), .fill_data(fill_data_a), .overrun(overrun_a),
      .miss_count(miss_count_a), .wb_count(wb_count_a));

   cache_miss_controller #(.RAM_LATENCY(3), .CNT_W(8)) dut_b (
      .clock(clock), .reset(reset), .miss_req(miss_req_b), .miss_addr(miss_addr),
      .victim_valid(victim_valid), .victim_dirty(victim_dirty),
      .victim_tag(victim_tag), .victim_data(victim_data),
      .mem_address(mem_address_b), .mem_data(mem_data_b), .mem_wren(mem_wren_b),
      .mem_q(mem_q_b), .busy(busy_b), .fill_valid(fill_valid_b),
      .fill_addr(fill_addr_b), .fill_data(fill_data_b), .overrun(overrun_b),
      .miss_count(miss_count_b), .wb_count(wb_count_b));

   // Backing RAM models: read data appears 1 (a) or 3 (b) cycles after the address edge.
   always @(posedge clock) begin
      if (ld_en) ram_a[ld_addr] <= ld_data;
      else if (mem_wren_a) ram_a[mem_address_a] <= mem_data_a;
      pipe_a[0] <= ram_a[mem_address_a];
      pipe_a[1] <= pipe_a[0];
      pipe_a[2] <= pipe_a[1];
   end
   always @(posedge clock) begin
      if (ld_en) ram_b[ld_addr] <= ld_data;
      else if (mem_wren_b) ram_b[mem_address_b] <= mem_data_b;
      pipe_b[0] <= ram_b[mem_address_b];
      pipe_b[1] <= pipe_b[0];
      pipe_b[2] <= pipe_b[1];
   end
   assign mem_q_a = pipe_a[0];
   assign mem_q_b = pipe_b[2];

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic load(input logic [4:0] a, input logic [7:0] d);
      ld_addr = a;
      ld_data = d;
      ld_en   = 1'b1;
      step();
      ld_en   = 1'b0;
   endtask

   task automatic set_victim(input logic v, input logic d, input logic [4:0] t, input logic [7:0] x);
      victim_valid = v;
      victim_dirty = d;
      victim_tag   = t;
      victim_data  = x;
   endtask

   initial begin
      reset = 1'b1;
      miss_req_a = 1'b0; miss_req_b = 1'b0;
      miss_addr = 5'd0;
      set_victim(1'b0, 1'b0, 5'd0, 8'd0);
      ld_en = 1'b0; ld_addr = 5'd0; ld_data = 8'd0;
      step();
      load(5'd7, 8'h3C);
      load(5'd3, 8'h11);
      load(5'd9, 8'h00);
      chk("rst_busy", 32'(busy_a), 0);
      chk("rst_wren", 32'(mem_wren_a), 0);
      chk("rst_fill_valid", 32'(fill_valid_a), 0);
      chk("rst_overrun", 32'(overrun_a), 0);
      chk("rst_counts", {16'd0, miss_count_a, wb_count_a}, 0);
      chk("rst_addr", 32'(mem_address_a), 0);
      reset = 1'b0;
      step();

      // Clean miss at latency 1: fill in cycle 3.
      set_victim(1'b0, 1'b0, 5'h1F, 8'hEE);
      miss_addr = 5'd7; miss_req_a = 1'b1;
      chk("c0_busy", 32'(busy_a), 0);
      step(); miss_req_a = 1'b0; miss_addr = 5'd0; victim_tag = 5'd4;
      chk("c1_addr", 32'(mem_address_a), 7);
      chk("c1_wren", 32'(mem_wren_a), 0);
      chk("c1_busy", 32'(busy_a), 1);
      chk("c1_miss_cnt", 32'(miss_count_a), 1);
      step();
      chk("c2_fill_valid", 32'(fill_valid_a), 0);
      chk("c2_wren", 32'(mem_wren_a), 0);
      step();
      chk("c3_fill_valid", 32'(fill_valid_a), 1);
      chk("c3_fill_data", 32'(fill_data_a), 32'h3C);
      chk("c3_fill_addr", 32'(fill_addr_a), 7);
      step();
      chk("c4_fill_valid", 32'(fill_valid_a), 0);
      chk("c4_busy", 32'(busy_a), 0);
      chk("c4_fill_hold", 32'(fill_data_a), 32'h3C);
      chk("c4_wb_cnt", 32'(wb_count_a), 0);

      // Dirty miss: writeback in cycle 1, fill in cycle 4.
      set_victim(1'b1, 1'b1, 5'h12, 8'hA5);
      miss_addr = 5'd3; miss_req_a = 1'b1;
      step(); miss_req_a = 1'b0; set_victim(1'b0, 1'b0, 5'd0, 8'd0);
      chk("d1_wren", 32'(mem_wren_a), 1);
      chk("d1_addr", 32'(mem_address_a), 32'h12);
      chk("d1_data", 32'(mem_data_a), 32'hA5);
      step();
      chk("d2_wren", 32'(mem_wren_a), 0);
      chk("d2_addr", 32'(mem_address_a), 3);
      step();
      chk("d3_fill_valid", 32'(fill_valid_a), 0);
      step();
      chk("d4_fill_valid", 32'(fill_valid_a), 1);
      chk("d4_fill_data", 32'(fill_data_a), 32'h11);
      chk("d4_fill_addr", 32'(fill_addr_a), 3);
      chk("d_ram_wb", 32'(ram_a[5'h12]), 32'hA5);
      chk("d_wb_cnt", 32'(wb_count_a), 1);
      chk("d_miss_cnt", 32'(miss_count_a), 2);
      step();

      // Valid=0, dirty=1: no writeback; reads back the earlier writeback data.
      set_victim(1'b0, 1'b1, 5'd7, 8'h55);
      miss_addr = 5'h12; miss_req_a = 1'b1;
      step(); miss_req_a = 1'b0;
      chk("nv1_wren", 32'(mem_wren_a), 0);
      chk("nv1_addr", 32'(mem_address_a), 32'h12);
      step(); step();
      chk("nv3_fill_valid", 32'(fill_valid_a), 1);
      chk("nv3_fill_data", 32'(fill_data_a), 32'hA5);
      chk("nv_wb_cnt", 32'(wb_count_a), 1);
      chk("nv_ram7", 32'(ram_a[5'd7]), 32'h3C);
      step();

      // Overrun: extra requests during WAIT and FILL are ignored.
      set_victim(1'b0, 1'b0, 5'd0, 8'd0);
      miss_addr = 5'd7; miss_req_a = 1'b1;
      fills = 0;
      step(); miss_req_a = 1'b0;
      chk("ov1_overrun", 32'(overrun_a), 0);
      step(); miss_req_a = 1'b1; miss_addr = 5'd3;
      step(); miss_req_a = 1'b1;
      chk("ov3_fill_data", 32'(fill_data_a), 32'h3C);
      chk("ov3_overrun", 32'(overrun_a), 1);
      if (fill_valid_a) fills++;
      step(); miss_req_a = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (fill_valid_a) fills++;
         step();
      end
      chk("ov_fill_pulses", 32'(fills), 1);
      chk("ov_miss_cnt", 32'(miss_count_a), 4);
      chk("ov_busy", 32'(busy_a), 0);
      chk("ov_sticky", 32'(overrun_a), 1);

      // Victim tag equals miss address: writeback first, read returns it.
      set_victim(1'b1, 1'b1, 5'd3, 8'h77);
      miss_addr = 5'd3; miss_req_a = 1'b1;
      step(); miss_req_a = 1'b0;
      step(); step(); step();
      chk("same_fill_valid", 32'(fill_valid_a), 1);
      chk("same_fill_data", 32'(fill_data_a), 32'h77);
      chk("same_wb_cnt", 32'(wb_count_a), 2);
      step();

      // Reset in the middle of the writeback cycle.
      set_victim(1'b1, 1'b1, 5'd9, 8'hC3);
      miss_addr = 5'd7; miss_req_a = 1'b1;
      step(); miss_req_a = 1'b0;
      chk("r_wb_wren", 32'(mem_wren_a), 1);
      #2 reset = 1'b1;
      #1;
      chk("r_wren_drop", 32'(mem_wren_a), 0);
      chk("r_busy_drop", 32'(busy_a), 0);
      chk("r_counts", {16'd0, miss_count_a, wb_count_a}, 0);
      chk("r_overrun", 32'(overrun_a), 0);
      #2 reset = 1'b0;
      fills = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (fill_valid_a) fills++;
      end
      chk("r_no_fill", 32'(fills), 0);
      chk("r_ram9", 32'(ram_a[5'd9]), 0);
      set_victim(1'b0, 1'b0, 5'd0, 8'd0);
      miss_addr = 5'd7; miss_req_a = 1'b1;
      step(); miss_req_a = 1'b0;
      step(); step();
      chk("r_new_fill", {23'd0, fill_valid_a, fill_data_a}, 32'h13C);
      chk("r_new_miss_cnt", 32'(miss_count_a), 1);
      step();

      // Latency 3: clean fill in cycle 5.
      set_victim(1'b0, 1'b0, 5'd0, 8'd0);
      miss_addr = 5'd7; miss_req_b = 1'b1;
      lat = -1;
      for (int c = 1; c <= 20; c++) begin
         step();
         miss_req_b = 1'b0;
         if (fill_valid_b) begin lat = c; break; end
      end
      chk("l3_clean_lat", 32'(lat), 5);
      chk("l3_clean_data", 32'(fill_data_b), 32'h3C);
      step();

      // Latency 3: dirty fill in cycle 6.
      set_victim(1'b1, 1'b1, 5'h12, 8'hA5);
      miss_addr = 5'd3; miss_req_b = 1'b1;
      lat = -1;
      for (int c = 1; c <= 20; c++) begin
         step();
         miss_req_b = 1'b0;
         if (fill_valid_b) begin lat = c; break; end
      end
      chk("l3_dirty_lat", 32'(lat), 6);
      chk("l3_dirty_data", 32'(fill_data_b), 32'h11);
      chk("l3_ram_wb", 32'(ram_b[5'h12]), 32'hA5);
      step();

      // 300 back-to-back clean misses: count saturates at 255.
      set_victim(1'b0, 1'b0, 5'd0, 8'd0);
      miss_addr = 5'd7;
      for (int i = 0; i < 300; i++) begin
         miss_req_b = 1'b1;
         step();
         miss_req_b = 1'b0;
         for (int k = 0; k < 12 && busy_b; k++) step();
         if (busy_b) begin
            chk("sat_timeout", 32'(busy_b), 0);
            break;
         end
      end
      chk("sat_miss_cnt", 32'(miss_count_b), 255);
      chk("sat_wb_cnt", 32'(wb_count_b), 1);
      chk("sat_overrun", 32'(overrun_b), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cache_miss_controller.md
Name: cache_miss_controller

Overview:
Sequences the shared 32x8 backing RAM (ramlpm) on behalf of the 4-line fully-associative cache whenever a lookup misses. Accepts one miss request carrying the requested address and the LRU victim line's state, writes the victim back if it is valid and dirty, then fetches the requested word. Returns the fetched word with a one-cycle fill strobe. Maintains saturating miss and writeback statistics.

Parameters:
RAM_LATENCY, 1, cycles from RAM address sample to valid mem_q. Legal range 1..3.
CNT_W, 8, width of the statistics counters.

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
miss_req  in  1  single-cycle miss strobe from the cache
miss_addr  in  5  word address that missed
victim_valid  in  1  valid bit of the LRU victim line
victim_dirty  in  1  dirty bit of the LRU victim line
victim_tag  in  5  tag (RAM address) of the victim line
victim_data  in  8  data held in the victim line
mem_address  out  5  RAM address
mem_data  out  8  RAM write data
mem_wren  out  1  RAM write enable
mem_q  in  8  RAM read data
busy  out  1  high while a miss is in flight
fill_valid  out  1  one-cycle strobe: fill_data/fill_addr valid
fill_addr  out  5  address of the filled word (captured miss_addr)
fill_data  out  8  word fetched from RAM
overrun  out  1  sticky: miss_req arrived while busy
miss_count  out  CNT_W  accepted misses, saturating
wb_count  out  CNT_W  writebacks performed, saturating

Behaviour:
- Reset (async, any state): state IDLE; all outputs 0, including mem_wren, fill_valid, overrun and both counters. Any in-flight miss is discarded with no fill. A writeback interrupted by reset must not be assumed complete.
- FSM states: IDLE, WB, RD, WAIT, FILL.
- IDLE: busy=0, mem_wren=0, mem_address=0, mem_data=0. If miss_req=1, capture miss_addr, victim_tag, victim_data and wb_needed=victim_valid&victim_dirty, increment miss_count, and go to WB if wb_needed, else RD.
- WB (1 cycle): mem_address=victim_tag, mem_data=victim_data, mem_wren=1. Increment wb_count. Go to RD.
- RD (1 cycle): mem_address=captured miss_addr, mem_wren=0. Go to WAIT with wait counter=RAM_LATENCY-1.
- WAIT (RAM_LATENCY cycles): mem_address stays at miss_addr. On the last WAIT cycle, register mem_q into fill_data, then go to FILL.
- FILL (1 cycle): fill_valid=1. fill_addr and fill_data are stable and held until the next fill. Return to IDLE. A miss_req in the FILL cycle counts as an overrun. The cache updates its line on the edge ending FILL.
- busy = (state != IDLE), decoded from state only. No combinational path from any input to any output.
- Latency, with miss_req in cycle 0: clean miss gives fill_valid in cycle 2+RAM_LATENCY; dirty miss gives 3+RAM_LATENCY.
- miss_req while busy: ignored (no capture, no count) and overrun set to 1. overrun clears only on reset.
- victim_* inputs are sampled only at acceptance. Later changes have no effect.
- Counters saturate at 2^CNT_W-1 and never wrap.
- The WB write always precedes the RD read. A victim_tag equal to miss_addr still writes back first, so the read returns the written-back data.

Test Plan:
- RAM_LATENCY=1, RAM[7]=0x3C, miss_req with miss_addr=7, victim clean -> no mem_wren; mem_address=7 in cycle 1; fill_valid in cycle 3 with fill_data=0x3C, fill_addr=7; miss_count=1, wb_count=0.
- Dirty victim (tag=0x12, data=0xA5), miss_addr=3, RAM[3]=0x11 -> mem_wren=1 with address 0x12, data 0xA5 in cycle 1 only; fill_valid in cycle 4 with 0x11; RAM[0x12]=0xA5 afterwards; wb_count=1.
- victim_valid=0, victim_dirty=1 -> no writeback; behaves as a clean miss.
- miss_req pulsed during WAIT and during FILL -> overrun=1; miss_count unchanged; exactly one fill_valid.
- Reset asserted mid-cycle during WB -> mem_wren and busy drop immediately; no fill_valid; counters=0. A new miss after reset completes normally.
- RAM_LATENCY=3: clean miss fills in cycle 5, dirty miss in cycle 6. 300 back-to-back misses -> miss_count saturates at 255.
